// File: rtl/pll_drp_ctrl.sv
// PLL reconfiguration sequencer: holds the PLL in reset, applies a table of DRP
// read-modify-write updates, releases reset and waits for lock.
module pll_drp_ctrl #(
    parameter int unsigned NUM_ENTRIES  = 23,
    parameter int unsigned TBL_AW       = 5,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned DRDY_TIMEOUT = 63,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_start,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [38:0]       tbl_data,
    output logic [6:0]        drp_daddr,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [15:0]       drp_di,
    input  logic [15:0]       drp_do,
    input  logic              drp_drdy,
    output logic              pll_rst,
    input  logic              pll_locked,
    output logic              locked_out
);

    localparam int unsigned CNT_MAX0 = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > LOCK_TIMEOUT) ? CNT_MAX0 : LOCK_TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W    = TBL_AW + 1;

    localparam logic [3:0] StPor      = 4'd0;
    localparam logic [3:0] StIdle     = 4'd1;
    localparam logic [3:0] StHold     = 4'd2;
    localparam logic [3:0] StFetch    = 4'd3;
    localparam logic [3:0] StRead     = 4'd4;
    localparam logic [3:0] StWaitRd   = 4'd5;
    localparam logic [3:0] StWrite    = 4'd6;
    localparam logic [3:0] StWaitWr   = 4'd7;
    localparam logic [3:0] StRelease  = 4'd8;
    localparam logic [3:0] StWaitLock = 4'd9;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [6:0]       addr_q, addr_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0]      data_q, data_d;
    logic [15:0]      di_q, di_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             lk_meta_q, lk_s_q;

    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        di_d    = di_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            StPor: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = StWaitLock;
            end
            StIdle: begin
                if (cfg_start) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = StFetch;
            end
            StFetch: state_d = StRead;
            StRead: begin
                addr_d  = tbl_data[38:32];
                mask_d  = tbl_data[31:16];
                data_d  = tbl_data[15:0];
                state_d = StWaitRd;
            end
            StWaitRd: begin
                if (drp_drdy) begin
                    // Mask bit set keeps the bit currently in the PLL register
                    di_d    = (drp_do & mask_q) | (data_q & ~mask_q);
                    state_d = StWrite;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end
            end
            StWrite: state_d = StWaitWr;
            StWaitWr: begin
                if (drp_drdy) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == IDX_W'(NUM_ENTRIES)) ? StRelease : StFetch;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StWaitLock;
            StWaitLock: begin
                if (lk_s_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StPor;
        endcase
        // One shared counter, restarted on every state change so each access gets a fresh budget
        cnt_d = ((state_d != state_q) || (state_q == StIdle)) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StPor;
            cnt_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            di_q      <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            di_q      <= di_d;
            err_q     <= err_d;
            done_q    <= done_d;
            lk_meta_q <= pll_locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    assign cfg_busy   = (state_q != StIdle);
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign tbl_addr   = idx_q[TBL_AW-1:0];
    assign drp_den    = (state_q == StRead) || (state_q == StWrite);
    assign drp_dwe    = (state_q == StWrite);
    assign drp_daddr  = (state_q == StRead) ? tbl_data[38:32] : addr_q;
    assign drp_di     = di_q;
    assign pll_rst    = (state_q == StPor)    || (state_q == StHold)   ||
                        (state_q == StFetch)  || (state_q == StRead)   ||
                        (state_q == StWaitRd) || (state_q == StWrite)  ||
                        (state_q == StWaitWr);
    assign locked_out = lk_s_q & ~cfg_busy;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: table ROM, DRP register model with write scoreboard, PLL lock model.
module tb_pll_drp_ctrl;

    localparam int unsigned NUM_ENTRIES  = 3;
    localparam int unsigned TBL_AW       = 5;
    localparam int unsigned RST_HOLD     = 16;
    localparam int unsigned DRDY_TIMEOUT = 63;
    // Shortened lock timeout keeps the lock-timeout scenario brief
    localparam int unsigned LOCK_TIMEOUT = 1000;
    localparam int          DRP_K        = 2;

    logic              refclk;
    logic              rst;
    logic              cfg_start;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;
    logic [TBL_AW-1:0] tbl_addr;
    logic [38:0]       tbl_data;
    logic [6:0]        drp_daddr;
    logic              drp_den;
    logic              drp_dwe;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do;
    logic              drp_drdy;
    logic              pll_rst;
    logic              pll_locked;
    logic              locked_out;

    pll_drp_ctrl #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .TBL_AW      (TBL_AW),
        .RST_HOLD    (RST_HOLD),
        .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .drp_daddr (drp_daddr),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy),
        .pll_rst   (pll_rst),
        .pll_locked(pll_locked),
        .locked_out(locked_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Preset table: {addr, keep-mask, data}
    logic [38:0] tbl [0:NUM_ENTRIES-1];
    initial begin
        tbl[0] = {7'h08, 16'h1000, 16'h0145};
        tbl[1] = {7'h09, 16'hFF00, 16'h00AA};
        tbl[2] = {7'h4E, 16'h0000, 16'h1234};
    end

    always @(posedge refclk)
        tbl_data <= (32'(tbl_addr) < NUM_ENTRIES) ? tbl[tbl_addr] : 39'h0;

    logic [15:0] drp_mem [0:127];
    logic [22:0] sb_q [$];
    logic [6:0]  hang_addr;
    int          lock_delay;
    logic        lock_en;

    int   cyc = 0, rd_cnt = 0, wr_cnt = 0, acc_4e = 0, done_cnt = 0;
    int   hang_den_cyc = 0, rst_fall_cyc = 0, rst_fall_wr = 0, done_cyc = 0;
    int   pend_cnt = 0, lock_ctr = 0;
    logic pend = 1'b0;
    logic prev_pll_rst = 1'b1;
    logic [15:0] pend_data;
    logic [22:0] exp_wr;

    initial begin
        for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0000;
        drp_mem[7'h08] = 16'hF2AB;
        drp_mem[7'h09] = 16'h1234;
        drp_mem[7'h4E] = 16'hFFFF;
        drp_drdy   = 1'b0;
        drp_do     = 16'h0;
        pll_locked = 1'b0;
    end

    // DRP and PLL models, evaluated shortly after each active edge
    always @(posedge refclk) begin
        #2;
        cyc++;
        drp_drdy = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = pend_data;
                    pend     = 1'b0;
                end
            end
            if (drp_den) begin
                check("den_while_pending", 32'(pend), 32'd0);
                if (drp_daddr == 7'h4E) acc_4e++;
                if (drp_dwe) begin
                    wr_cnt++;
                    check("pll_rst_at_write", 32'(pll_rst), 32'd1);
                    if (sb_q.size() == 0) begin
                        check("unexpected_write", 32'({drp_daddr, drp_di}), 32'h7FFFFF);
                    end else begin
                        exp_wr = sb_q.pop_front();
                        check("drp_write", 32'({drp_daddr, drp_di}), 32'(exp_wr));
                    end
                    drp_mem[drp_daddr] = drp_di;
                end else begin
                    rd_cnt++;
                end
                if (drp_dwe || drp_daddr != hang_addr) begin
                    pend      = 1'b1;
                    pend_cnt  = DRP_K;
                    pend_data = drp_mem[drp_daddr];
                end else begin
                    hang_den_cyc = cyc;
                end
            end
        end
        if (prev_pll_rst && !pll_rst) begin
            rst_fall_cyc = cyc;
            rst_fall_wr  = wr_cnt;
        end
        prev_pll_rst = pll_rst;
        if (cfg_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pll_rst || !lock_en) begin
            lock_ctr   = 0;
            pll_locked = 1'b0;
        end else begin
            if (lock_ctr < lock_delay) lock_ctr++;
            pll_locked = (lock_ctr >= lock_delay);
        end
    end

    task automatic push_expected(input int n);
        logic [6:0]  a;
        logic [15:0] m, d, rb;
        for (int i = 0; i < n; i++) begin
            a  = tbl[i][38:32];
            m  = tbl[i][31:16];
            d  = tbl[i][15:0];
            rb = drp_mem[a];
            sb_q.push_back({a, (rb & m) | (d & ~m)});
        end
    endtask

    task automatic start_cfg();
        cfg_start = 1'b1;
        @(negedge refclk);
        cfg_start = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge refclk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int c);
        c = 0;
        while (!cfg_done && c < budget) begin
            @(negedge refclk);
            c++;
        end
        check(tag, 32'(cfg_done), 32'd1);
    endtask

    task automatic count_rst_hold(input string tag);
        int n;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge refclk);
        end
        check(tag, 32'(n), 32'(RST_HOLD));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    int n, rd0, wr0, d0, a0;

    initial begin
        rst        = 1'b1;
        cfg_start  = 1'b0;
        lock_en    = 1'b1;
        lock_delay = 84;
        hang_addr  = 7'h7F;
        repeat (3) @(negedge refclk);
        check("reset_pll_rst", 32'(pll_rst), 32'd1);
        check("reset_busy", 32'(cfg_busy), 32'd1);
        check("reset_flags", 32'({cfg_done, cfg_err, drp_den, drp_dwe, locked_out}), 32'd0);
        check("reset_buses", 32'({drp_daddr, drp_di, tbl_addr}), 32'd0);

        // Power-on sequence
        rst = 1'b0;
        count_rst_hold("por_rst_hold");
        n = 0;
        while (!pll_locked && n < 300) begin
            n++;
            @(negedge refclk);
        end
        check("por_lock_seen", 32'(pll_locked), 32'd1);
        wait_done("por_done", 20, n);
        check("por_lock_to_done", 32'(n >= 2 && n <= 3), 32'd1);
        check("por_idle_state", 32'({cfg_busy, cfg_err, locked_out}), 32'b001);

        // Full reconfiguration
        lock_delay = 20;
        rd0 = rd_cnt; wr0 = wr_cnt;
        push_expected(3);
        start_cfg();
        check("start_busy_rst", 32'({cfg_busy, pll_rst}), 32'b11);
        check("start_locked_gated", 32'(locked_out), 32'd0);
        n = 0;
        while (!drp_den && n < 100) begin
            @(negedge refclk);
            n++;
        end
        check("first_den_latency", 32'(n), 32'(RST_HOLD + 1));
        check("first_den_addr", 32'({drp_daddr, drp_dwe}), 32'({7'h08, 1'b0}));
        wait_done("cfg_done", 2000, n);
        check("cfg_reads", 32'(rd_cnt - rd0), 32'd3);
        check("cfg_writes", 32'(wr_cnt - wr0), 32'd3);
        check("cfg_sb_empty", 32'(sb_q.size()), 32'd0);
        check("cfg_rst_after_last_wr", 32'(rst_fall_wr), 32'(wr0 + 3));
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        check("cfg_busy_at_done", 32'(cfg_busy), 32'd0);
        check("entry0_value", 32'(drp_mem[7'h08]), 32'h1145);
        check("entry1_value", 32'(drp_mem[7'h09]), 32'h12AA);

        // Start requests while busy are ignored
        repeat (5) @(negedge refclk);
        rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
        push_expected(3);
        start_cfg();
        repeat (3) @(negedge refclk);
        pulse_start();
        n = 0;
        while (!(drp_den && !drp_dwe) && n < 100) begin
            @(negedge refclk);
            n++;
        end
        @(negedge refclk);
        pulse_start();
        wait_done("busy_done", 2000, n);
        repeat (40) @(negedge refclk);
        check("busy_single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_reads", 32'(rd_cnt - rd0), 32'd3);
        check("busy_writes", 32'(wr_cnt - wr0), 32'd3);
        check("busy_still_idle", 32'(cfg_busy), 32'd0);

        // DRP never answers entry 1
        hang_addr = 7'h09;
        rd0 = rd_cnt; wr0 = wr_cnt; a0 = acc_4e;
        push_expected(1);
        start_cfg();
        wait_done("drdy_to_done", 3000, n);
        check("drdy_to_err", 32'(cfg_err), 32'd1);
        check("drdy_to_reads", 32'(rd_cnt - rd0), 32'd2);
        check("drdy_to_writes", 32'(wr_cnt - wr0), 32'd1);
        check("drdy_to_entry2_skipped", 32'(acc_4e - a0), 32'd0);
        check("drdy_to_release_time", 32'(rst_fall_cyc - hang_den_cyc), 32'(DRDY_TIMEOUT + 1));
        check("drdy_to_pll_rst", 32'(pll_rst), 32'd0);
        hang_addr = 7'h7F;

        // Lock never arrives
        repeat (5) @(negedge refclk);
        lock_en = 1'b0;
        push_expected(3);
        start_cfg();
        wait_done("lock_to_done", 3000, n);
        check("lock_to_err", 32'(cfg_err), 32'd1);
        check("lock_to_time", 32'(done_cyc - rst_fall_cyc), 32'(LOCK_TIMEOUT + 1));
        check("lock_to_pll_rst", 32'(pll_rst), 32'd0);
        lock_en = 1'b1;
        repeat (5) @(negedge refclk);
        push_expected(3);
        start_cfg();
        check("start_clears_err", 32'(cfg_err), 32'd0);
        wait_done("relock_done", 2000, n);
        check("relock_err", 32'(cfg_err), 32'd0);
        check("relock_locked_out", 32'(locked_out), 32'd1);

        // Reset in the middle of a write access
        repeat (5) @(negedge refclk);
        push_expected(3);
        start_cfg();
        n = 0;
        while (!(drp_den && drp_dwe) && n < 200) begin
            @(negedge refclk);
            n++;
        end
        @(negedge refclk);
        rst = 1'b1;
        #1;
        check("midrst_drp_strobes", 32'({drp_den, drp_dwe}), 32'd0);
        check("midrst_rst_busy", 32'({pll_rst, cfg_busy}), 32'b11);
        sb_q.delete();
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        count_rst_hold("midrst_por_hold");
        wait_done("midrst_por_done", 300, n);
        check("midrst_final", 32'({cfg_busy, cfg_err, locked_out}), 32'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
